// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link (PISO transmitter and SIPO receiver).
// State encoding, default word length and default bit order.
package serial_link_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam int DEF_WIDTH     = 4;
   localparam bit DEF_MSB_FIRST = 1'b1;

endpackage

// File: rtl/bit_period_counter.sv
// Divider counting clk cycles within one serial bit period, mod BIT_DIV.
// Clear forces zero; tc flags the last cycle of the bit period.
module bit_period_counter #(
   parameter int BIT_DIV = 1,
   parameter int DW      = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          en,
   output logic [DW-1:0] cnt,
   output logic          tc
);

   assign tc = (cnt == DW'(BIT_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + DW'(1);
      end
   end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and
// programmable bit period; back-to-back words leave no idle gap.
module piso_serial_tx
   import serial_link_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int BIT_DIV    = 1,
   parameter bit MSB_FIRST  = DEF_MSB_FIRST,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             tx_done
);

   localparam int BW = $clog2(WIDTH);
   localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

   state_t           state;
   logic [BW-1:0]    bit_cnt;
   logic [DW-1:0]    div_cnt;
   logic             div_tc;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shnext;
   logic             last;
   logic             accept;

   function automatic logic head(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   assign last       = (bit_cnt == BW'(WIDTH - 1)) & div_tc;
   assign tx_done    = (state == ST_SHIFT) & last;
   assign load_ready = !rst & ((state == ST_IDLE) | tx_done);
   assign accept     = load_valid & load_ready;
   assign shnext     = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

   bit_period_counter #(
      .BIT_DIV (BIT_DIV),
      .DW      (DW)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .clear (accept),
      .en    (state == ST_SHIFT),
      .cnt   (div_cnt),
      .tc    (div_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         shreg        <= '0;
         serial_out   <= IDLE_LEVEL;
         serial_valid <= 1'b0;
      end else if (accept) begin
         // Covers both IDLE loads and back-to-back loads on the last cycle
         state        <= ST_SHIFT;
         bit_cnt      <= '0;
         shreg        <= parallel_in;
         serial_out   <= head(parallel_in);
         serial_valid <= 1'b1;
      end else begin
         case (state)
            ST_SHIFT: begin
               if (div_tc) begin
                  if (last) begin
                     state        <= ST_IDLE;
                     bit_cnt      <= '0;
                     serial_out   <= IDLE_LEVEL;
                     serial_valid <= 1'b0;
                  end else begin
                     bit_cnt    <= bit_cnt + BW'(1);
                     shreg      <= shnext;
                     serial_out <= head(shnext);
                  end
               end
            end
            default: begin
               serial_out   <= IDLE_LEVEL;
               serial_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
